// File: rtl/usb_fsi_pkg.sv
// Shared FSI frame constants, channel codes and FSM state encodings.
// Pure definitions: no latency or backpressure of its own.
package usb_fsi_pkg;

   localparam int FSI_FRAME_BITS = 10;
   localparam int FSI_DATA_BITS  = 8;

   localparam logic FSI_CH_A = 1'b0;
   localparam logic FSI_CH_B = 1'b1;

   typedef enum logic {
      RX_IDLE,
      RX_SHIFT
   } rx_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_SHIFT,
      TX_CHAN
   } tx_state_e;

endpackage

// File: rtl/usb_fsi_sync_edge.sv
// Synchronizes an async level into clk_i and emits 1-cycle rise/fall pulses.
// Latency STAGES+1 cycles from pin to pulse; no backpressure.
module usb_fsi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Idle level of the FSI clock is high, so reset to 1 to avoid a spurious edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/usb_ftdi_fsi_device.sv
// Device-side FSI endpoint: one-entry RX buffer with CTS flow control, TX serializer with collision retry.
// RX byte valid ~SYNC_STAGES+2 i_clk after the channel-bit rise; TX accepts only while o_tx_busy is low.
module usb_ftdi_fsi_device
   import usb_fsi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_fsi_clk,
   input  logic       i_fsi_si,
   output logic       o_fsi_so,
   output logic       o_fsi_cts,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic       o_rx_channel,
   output logic [7:0] o_rx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_busy,
   input  logic       i_tx_channel,
   input  logic [7:0] i_tx_data
);

   logic fclk_rise;
   logic fclk_fall;

   usb_fsi_sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_clk_sync (
      .clk_i  (i_clk),
      .rst_i  (i_reset),
      .d_i    (i_fsi_clk),
      .rise_o (fclk_rise),
      .fall_o (fclk_fall)
   );

   // SI takes the same depth as the clock so the sampled bit lines up with the detected rise.
   logic [SYNC_STAGES-1:0] si_sync_q;
   logic                   si_s;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) si_sync_q <= '1;
      else         si_sync_q <= {si_sync_q[SYNC_STAGES-2:0], i_fsi_si};
   end

   assign si_s = si_sync_q[SYNC_STAGES-1];

   rx_state_e  rx_state_q, rx_state_d;
   logic [3:0] rx_cnt_q,   rx_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] rx_data_q,  rx_data_d;
   logic       rx_chan_q,  rx_chan_d;
   logic       rx_valid_q, rx_valid_d;
   logic       cts_q,      cts_d;
   logic       rx_done;

   tx_state_e  tx_state_q, tx_state_d;
   logic [3:0] tx_idx_q,   tx_idx_d;
   logic [7:0] tx_data_q,  tx_data_d;
   logic       tx_chan_q,  tx_chan_d;
   logic       tx_busy_q,  tx_busy_d;
   logic       tx_coll_q,  tx_coll_d;
   logic       so_q,       so_d;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;

      case (rx_state_q)
         RX_IDLE: begin
            if (fclk_rise && !si_s) begin
               rx_state_d = RX_SHIFT;
               rx_cnt_d   = 4'd0;
            end
         end
         RX_SHIFT: begin
            if (fclk_rise) begin
               if (rx_cnt_q == 4'(FSI_DATA_BITS)) begin
                  rx_done    = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_shift_d = {si_s, rx_shift_q[7:1]};
                  rx_cnt_d   = rx_cnt_q + 4'd1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase

      rx_data_d = rx_done ? rx_shift_q : rx_data_q;
      rx_chan_d = rx_done ? si_s       : rx_chan_q;

      // A completing frame wins over a same-cycle pop so the new byte is never lost.
      rx_valid_d = rx_valid_q;
      if (rx_done)
         rx_valid_d = 1'b1;
      else if (rx_valid_q && i_rx_ready)
         rx_valid_d = 1'b0;

      // Looking at both old and new valid holds CTS low for the pop cycle and on frame completion.
      cts_d = (rx_state_d == RX_IDLE) && !rx_valid_d && !rx_valid_q;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_idx_d   = tx_idx_q;
      tx_data_d  = tx_data_q;
      tx_chan_d  = tx_chan_q;
      tx_busy_d  = tx_busy_q;
      tx_coll_d  = tx_coll_q;
      so_d       = so_q;

      if (i_tx_valid && !tx_busy_q) begin
         tx_data_d = i_tx_data;
         tx_chan_d = i_tx_channel;
         tx_busy_d = 1'b1;
      end

      case (tx_state_q)
         TX_IDLE: begin
            if (tx_busy_q && (rx_state_q == RX_IDLE) && fclk_fall) begin
               so_d       = 1'b0;
               tx_coll_d  = 1'b0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            // Host start on the same rise as ours: back off, keep the byte, retry after its frame.
            if (fclk_rise && !si_s && (rx_state_q == RX_IDLE))
               tx_coll_d = 1'b1;
            if (fclk_fall) begin
               if (tx_coll_q) begin
                  so_d       = 1'b1;
                  tx_state_d = TX_IDLE;
               end else begin
                  so_d       = tx_data_q[0];
                  tx_idx_d   = 4'd1;
                  tx_state_d = TX_SHIFT;
               end
            end
         end
         TX_SHIFT: begin
            if (fclk_fall) begin
               if (tx_idx_q == 4'(FSI_DATA_BITS)) begin
                  so_d       = tx_chan_q;
                  tx_state_d = TX_CHAN;
               end else begin
                  so_d     = tx_data_q[tx_idx_q[2:0]];
                  tx_idx_d = tx_idx_q + 4'd1;
               end
            end
         end
         TX_CHAN: begin
            if (fclk_fall) begin
               so_d       = 1'b1;
               tx_busy_d  = 1'b0;
               tx_state_d = TX_IDLE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= 4'd0;
         rx_shift_q <= 8'd0;
         rx_data_q  <= 8'd0;
         rx_chan_q  <= FSI_CH_A;
         rx_valid_q <= 1'b0;
         cts_q      <= 1'b0;
         tx_state_q <= TX_IDLE;
         tx_idx_q   <= 4'd0;
         tx_data_q  <= 8'd0;
         tx_chan_q  <= FSI_CH_A;
         tx_busy_q  <= 1'b0;
         tx_coll_q  <= 1'b0;
         so_q       <= 1'b1;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_chan_q  <= rx_chan_d;
         rx_valid_q <= rx_valid_d;
         cts_q      <= cts_d;
         tx_state_q <= tx_state_d;
         tx_idx_q   <= tx_idx_d;
         tx_data_q  <= tx_data_d;
         tx_chan_q  <= tx_chan_d;
         tx_busy_q  <= tx_busy_d;
         tx_coll_q  <= tx_coll_d;
         so_q       <= so_d;
      end
   end

   assign o_fsi_so     = so_q;
   assign o_fsi_cts    = cts_q;
   assign o_rx_valid   = rx_valid_q;
   assign o_rx_channel = rx_chan_q;
   assign o_rx_data    = rx_data_q;
   assign o_tx_busy    = tx_busy_q;

endmodule
